// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, sample-tick
// positions within a 16-tick bit period, and the 3-sample majority vote.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int         BYTE_W     = 8;
    localparam logic [3:0] TICK_SAMP0 = 4'd7;
    localparam logic [3:0] TICK_SAMP1 = 4'd8;
    localparam logic [3:0] TICK_SAMP2 = 4'd9;
    localparam logic [3:0] TICK_LAST  = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// First-word-fall-through byte FIFO: synchronous write, combinational head read,
// pointers one bit wider than the address so full and empty are distinguishable.
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic              empty,
    output logic              dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BYTE_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                full;
    logic                do_pop;
    logic                do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign rdata   = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and majority-vote bit decisions,
// feeding a FWFT FIFO read by edge-detected cpu read strobes.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                baudclk16,
    input  logic                rxd,
    output logic [7:0]          data,
    output logic                ready,
    input  logic                read,
    output logic [DEPTH_LOG2:0] count,
    output logic                framing_err,
    output logic                overrun,
    input  logic                clear_err
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    rx_state_t              state, state_n;
    logic [3:0]             tick, tick_n;
    logic [2:0]             bit_idx, bit_n;
    logic [1:0]             samp, samp_n;
    logic [BYTE_W-1:0]      shreg, shreg_n;
    logic                   vote;
    logic                   push;
    logic                   ferr_set;
    logic                   read_q;
    logic                   pop;
    logic                   empty;
    logic                   dropped;

    assign rxd_s = sync[SYNC_STAGES-1];
    assign vote  = majority3(samp[0], samp[1], rxd_s);
    assign pop   = read & ~read_q;
    assign ready = ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync        <= '1;
            state       <= ST_IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            samp        <= '0;
            read_q      <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rxd};
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_n;
            samp    <= samp_n;
            read_q  <= read;
            if (ferr_set)       framing_err <= 1'b1;
            else if (clear_err) framing_err <= 1'b0;
            if (dropped)        overrun <= 1'b1;
            else if (clear_err) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        bit_n    = bit_idx;
        samp_n   = samp;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (baudclk16) begin
            if (tick == TICK_SAMP0) samp_n[0] = rxd_s;
            if (tick == TICK_SAMP1) samp_n[1] = rxd_s;
            tick_n = tick + 4'd1;
            unique case (state)
                ST_IDLE: begin
                    tick_n = '0;
                    if (!rxd_s) state_n = ST_START;
                end
                ST_START: begin
                    if (tick == TICK_SAMP2 && vote) begin
                        state_n = ST_IDLE;
                        tick_n  = '0;
                    end else if (tick == TICK_LAST) begin
                        state_n = ST_DATA;
                        bit_n   = '0;
                    end
                end
                ST_DATA: begin
                    if (tick == TICK_SAMP2) shreg_n = {vote, shreg[BYTE_W-1:1]};
                    if (tick == TICK_LAST) begin
                        if (bit_idx == 3'd7) state_n = ST_STOP;
                        else                 bit_n   = bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Decide at mid-stop-bit so the next start edge is never missed.
                    if (tick == TICK_SAMP2) begin
                        tick_n = '0;
                        if (vote) begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_n  = ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    tick_n = '0;
                    if (rxd_s) state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    tick_n  = '0;
                end
            endcase
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (shreg),
        .rdata   (data),
        .count   (count),
        .empty   (empty),
        .dropped (dropped)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven tick-aligned to baudclk16,
// outputs sampled 1 time unit after the clock edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baudclk16 = 1'b0;
    logic       rxd = 1'b1;
    logic       read = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       framing_err;
    logic       overrun;

    int baud_div = 34;
    int div_cnt  = 0;
    int tests    = 0;
    int fails    = 0;

    uart_rx_fifo #(.DEPTH_LOG2(3), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .baudclk16   (baudclk16),
        .rxd         (rxd),
        .data        (data),
        .ready       (ready),
        .read        (read),
        .count       (count),
        .framing_err (framing_err),
        .overrun     (overrun),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_cnt >= baud_div - 1) begin
            div_cnt   <= 0;
            baudclk16 <= 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1;
            baudclk16 <= 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!baudclk16);
        end
        #1;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        wait_clks(1);
        read = 1'b0;
        wait_clks(1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        wait_clks(1);
        clear_err = 1'b0;
    endtask

    // Leaves rxd at the stop-bit level; pop_at_push raises read so its edge
    // lands on the cycle the receiver decides the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_push);
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_ticks(16);
        end
        rxd = stop_bit;
        if (!pop_at_push) begin
            wait_ticks(16);
        end else begin
            wait_ticks(10);
            while (!baudclk16) begin
                @(posedge clk);
                #1;
            end
            read = 1'b1;
            wait_ticks(1);
            read = 1'b0;
            wait_ticks(5);
        end
    endtask

    initial begin
        logic [7:0] exp_tail [8];

        wait_clks(3);
        check("rst_ready", ready, 0);
        check("rst_count", count, 0);
        check("rst_data", data, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        wait_clks(2);

        // Single frame at the slow baud rate, then an edge pop.
        send_frame(8'hA5, 1'b1, 0);
        wait_clks(4);
        check("a5_ready", ready, 1);
        check("a5_data", data, 8'hA5);
        check("a5_count", count, 1);
        read = 1'b1;
        wait_clks(1);
        check("a5_pop_ready", ready, 0);
        check("a5_pop_count", count, 0);
        wait_clks(3);
        read = 1'b0;
        wait_clks(1);
        pulse_read();
        check("empty_pop_count", count, 0);
        check("empty_pop_ready", ready, 0);

        baud_div = 8;
        wait_ticks(2);

        // Short low glitch must be rejected in START.
        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        wait_ticks(30);
        check("glitch_ready", ready, 0);
        check("glitch_count", count, 0);
        check("glitch_ferr", framing_err, 0);

        // Framing error followed by a long break.
        send_frame(8'h3C, 1'b0, 0);
        wait_ticks(40 * 16);
        check("brk_ferr", framing_err, 1);
        check("brk_count", count, 0);
        rxd = 1'b1;
        wait_ticks(40);
        check("brk_idle_count", count, 0);
        check("brk_ready", ready, 0);
        pulse_clear();
        check("ferr_cleared", framing_err, 0);

        // Nine bytes into an 8-deep FIFO.
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1, 0);
        wait_ticks(4);
        check("ovf_count", count, 8);
        check("ovf_flag", overrun, 1);
        check("ovf_head", data, 8'h01);
        read = 1'b1;
        wait_clks(5);
        read = 1'b0;
        wait_clks(1);
        check("held_read_once", count, 7);
        for (int b = 2; b <= 8; b++) begin
            check("ovf_order", data, b);
            pulse_read();
        end
        check("ovf_drained_ready", ready, 0);
        check("ovf_drained_count", count, 0);
        pulse_clear();
        check("ovr_cleared", overrun, 0);

        // Full FIFO with a pop coinciding with the next push.
        for (int b = 8'h11; b <= 8'h18; b++) send_frame(8'(b), 1'b1, 0);
        wait_ticks(2);
        check("full_count", count, 8);
        check("full_head", data, 8'h11);
        send_frame(8'h55, 1'b1, 1);
        check("pp_count", count, 8);
        check("pp_ovr", overrun, 0);
        exp_tail = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        for (int i = 0; i < 8; i++) begin
            check("pp_order", data, exp_tail[i]);
            pulse_read();
        end
        check("pp_drained_ready", ready, 0);

        // Reset in the middle of data bit 4.
        send_frame(8'h42, 1'b1, 0);
        wait_clks(4);
        check("pre_rst_count", count, 1);
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(16 + 64 + 8);
        reset = 1'b1;
        wait_clks(1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_ferr", framing_err, 0);
        check("mid_rst_ovr", overrun, 0);
        rxd = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_ticks(20);
        check("post_rst_ready", ready, 0);
        send_frame(8'h7E, 1'b1, 0);
        wait_clks(4);
        check("post_rst_rx_ready", ready, 1);
        check("post_rst_rx_data", data, 8'h7E);
        check("post_rst_rx_count", count, 1);
        check("post_rst_ferr", framing_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
